// File: rtl/elevator_pkg.sv
// Shared encodings for the SCAN elevator controller: actuator codes, door
// feedback codes, service direction and the controller state enum.
package elevator_pkg;

    localparam logic [1:0] ENG_STOP   = 2'b00;
    localparam logic [1:0] ENG_UP     = 2'b01;
    localparam logic [1:0] ENG_DOWN   = 2'b10;

    localparam logic [1:0] DOOR_HOLD  = 2'b00;
    localparam logic [1:0] DOOR_OPEN  = 2'b01;
    localparam logic [1:0] DOOR_CLOSE = 2'b10;

    localparam logic [1:0] SD_TRANSIT = 2'b00;
    localparam logic [1:0] SD_OPEN    = 2'b01;
    localparam logic [1:0] SD_CLOSED  = 2'b10;
    localparam logic [1:0] SD_INVALID = 2'b11;

    localparam logic [1:0] DIR_NONE   = 2'b00;
    localparam logic [1:0] DIR_UP     = 2'b01;
    localparam logic [1:0] DIR_DOWN   = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MOVE_UP,
        ST_MOVE_DOWN,
        ST_DOOR_OPENING,
        ST_DOOR_OPEN,
        ST_DOOR_CLOSING,
        ST_FAULT
    } state_t;

endpackage

// File: rtl/elevator_req_queue.sv
// Latched car/hall call registers with per-floor lamps and the above/below/here
// reductions the scheduler needs for a queried floor.
module elevator_req_queue #(
    parameter int unsigned FLOORS  = 8,
    parameter int unsigned LEVEL_W = $clog2(FLOORS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [FLOORS-1:0]  btn_in,
    input  logic [FLOORS-1:0]  btn_up_out,
    input  logic [FLOORS-1:0]  btn_down_out,
    input  logic [LEVEL_W-1:0] level,
    input  logic               clr_car,
    input  logic               clr_up,
    input  logic               clr_down,
    output logic [FLOORS-1:0]  req_lamp,
    output logic               req_above,
    output logic               req_below,
    output logic               req_here_car,
    output logic               req_here_up,
    output logic               req_here_down
);

    // No up call exists at the top floor, no down call at the bottom floor.
    localparam logic [FLOORS-1:0] UP_MASK   = {1'b0, {(FLOORS-1){1'b1}}};
    localparam logic [FLOORS-1:0] DOWN_MASK = {{(FLOORS-1){1'b1}}, 1'b0};

    logic [FLOORS-1:0] car_q, up_q, down_q;
    logic [FLOORS-1:0] car_d, up_d, down_d;
    logic [FLOORS-1:0] level_sel;
    logic [FLOORS-1:0] any_req;

    assign level_sel = FLOORS'(1) << level;

    // A press in the same cycle as a clear keeps the call pending.
    always_comb begin
        car_d  = (car_q & ~(level_sel & {FLOORS{clr_car}})) | btn_in;
        up_d   = ((up_q & ~(level_sel & {FLOORS{clr_up}})) | btn_up_out) & UP_MASK;
        down_d = ((down_q & ~(level_sel & {FLOORS{clr_down}})) | btn_down_out) & DOWN_MASK;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            car_q    <= '0;
            up_q     <= '0;
            down_q   <= '0;
            req_lamp <= '0;
        end else begin
            car_q    <= car_d;
            up_q     <= up_d;
            down_q   <= down_d;
            req_lamp <= car_d | up_d | down_d;
        end
    end

    assign any_req       = car_q | up_q | down_q;
    assign req_here_car  = |(car_q & level_sel);
    assign req_here_up   = |(up_q & level_sel);
    assign req_here_down = |(down_q & level_sel);

    always_comb begin
        req_above = 1'b0;
        req_below = 1'b0;
        for (int unsigned i = 0; i < FLOORS; i++) begin
            if (LEVEL_W'(i) > level) req_above = req_above | any_req[i];
            if (LEVEL_W'(i) < level) req_below = req_below | any_req[i];
        end
    end

endmodule

// File: rtl/elevator_scan.sv
// Single-car collective-selective (SCAN) elevator controller with door dwell,
// motion watchdog and sticky fault.
module elevator_scan
    import elevator_pkg::*;
#(
    parameter int unsigned FLOORS       = 8,
    parameter int unsigned LEVEL_W      = $clog2(FLOORS),
    parameter int unsigned DOOR_TIME    = 16,
    parameter int unsigned MOVE_TIMEOUT = 256
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               open_btn,
    input  logic               close_btn,
    input  logic               overload,
    input  logic               sensor_inside,
    input  logic               sensor_up,
    input  logic               sensor_down,
    input  logic [1:0]         sensor_door,
    input  logic [FLOORS-1:0]  btn_in,
    input  logic [FLOORS-1:0]  btn_up_out,
    input  logic [FLOORS-1:0]  btn_down_out,
    output logic [1:0]         engine,
    output logic [1:0]         door,
    output logic [LEVEL_W-1:0] level_display,
    output logic [FLOORS-1:0]  req_lamp,
    output logic [1:0]         dir_ind,
    output logic               fault
);

    localparam int unsigned DWELL_W = $clog2(DOOR_TIME + 1);
    localparam int unsigned MOVE_W  = $clog2(MOVE_TIMEOUT + 1);
    localparam logic [LEVEL_W-1:0] TOP_LEVEL  = LEVEL_W'(FLOORS - 1);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DOOR_TIME - 1);
    localparam logic [MOVE_W-1:0]  MOVE_LAST  = MOVE_W'(MOVE_TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [LEVEL_W-1:0] level_d, query_level;
    logic [1:0]         dir_d, engine_d, door_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [MOVE_W-1:0]  move_q, move_d;
    logic               fault_d, fault_event;
    logic               clr_car, clr_up, clr_down;
    logic               req_above, req_below;
    logic               req_here_car, req_here_up, req_here_down;

    elevator_req_queue #(
        .FLOORS (FLOORS),
        .LEVEL_W(LEVEL_W)
    ) u_req_queue (
        .clk          (clk),
        .reset        (reset),
        .btn_in       (btn_in),
        .btn_up_out   (btn_up_out),
        .btn_down_out (btn_down_out),
        .level        (query_level),
        .clr_car      (clr_car),
        .clr_up       (clr_up),
        .clr_down     (clr_down),
        .req_lamp     (req_lamp),
        .req_above    (req_above),
        .req_below    (req_below),
        .req_here_car (req_here_car),
        .req_here_up  (req_here_up),
        .req_here_down(req_here_down)
    );

    // While moving, the stop decision looks at the floor being arrived at.
    always_comb begin
        query_level = level_display;
        if (state_q == ST_MOVE_UP && sensor_up) begin
            query_level = level_display + LEVEL_W'(1);
        end else if (state_q == ST_MOVE_DOWN && sensor_down) begin
            query_level = level_display - LEVEL_W'(1);
        end
    end

    assign fault_event = (sensor_up && sensor_down)
                      || (sensor_up && (engine != ENG_UP || level_display == TOP_LEVEL))
                      || (sensor_down && (engine != ENG_DOWN || level_display == '0))
                      || (sensor_door == SD_INVALID);

    // Next-state, service-direction, timer and call-clear logic.
    always_comb begin
        state_d  = state_q;
        level_d  = level_display;
        dir_d    = dir_ind;
        dwell_d  = dwell_q;
        move_d   = '0;
        fault_d  = fault;
        clr_car  = 1'b0;
        clr_up   = 1'b0;
        clr_down = 1'b0;
        engine_d = ENG_STOP;
        door_d   = DOOR_HOLD;

        if (state_q != ST_FAULT && fault_event) begin
            state_d = ST_FAULT;
            fault_d = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_here_car || req_here_up || req_here_down || open_btn) begin
                        state_d = ST_DOOR_OPENING;
                    end else if (dir_ind == DIR_UP && req_above) begin
                        state_d = ST_MOVE_UP;
                    end else if (dir_ind == DIR_DOWN && req_below) begin
                        state_d = ST_MOVE_DOWN;
                    end else if (req_above) begin
                        state_d = ST_MOVE_UP;
                        dir_d   = DIR_UP;
                    end else if (req_below) begin
                        state_d = ST_MOVE_DOWN;
                        dir_d   = DIR_DOWN;
                    end else begin
                        dir_d = DIR_NONE;
                    end
                end
                ST_MOVE_UP: begin
                    if (sensor_up) begin
                        level_d = query_level;
                        if (req_here_car || req_here_up || (req_here_down && !req_above)) begin
                            state_d = ST_DOOR_OPENING;
                        end
                    end else if (move_q == MOVE_LAST) begin
                        state_d = ST_FAULT;
                        fault_d = 1'b1;
                    end else begin
                        move_d = move_q + MOVE_W'(1);
                    end
                end
                ST_MOVE_DOWN: begin
                    if (sensor_down) begin
                        level_d = query_level;
                        if (req_here_car || req_here_down || (req_here_up && !req_below)) begin
                            state_d = ST_DOOR_OPENING;
                        end
                    end else if (move_q == MOVE_LAST) begin
                        state_d = ST_FAULT;
                        fault_d = 1'b1;
                    end else begin
                        move_d = move_q + MOVE_W'(1);
                    end
                end
                ST_DOOR_OPENING: begin
                    dwell_d = '0;
                    if (sensor_door == SD_OPEN) begin
                        state_d = ST_DOOR_OPEN;
                        clr_car = 1'b1;
                        case (dir_ind)
                            DIR_UP: begin
                                clr_up = 1'b1;
                                if (!req_above) begin
                                    dir_d    = DIR_DOWN;
                                    clr_down = 1'b1;
                                end
                            end
                            DIR_DOWN: begin
                                clr_down = 1'b1;
                                if (!req_below) begin
                                    dir_d  = DIR_UP;
                                    clr_up = 1'b1;
                                end
                            end
                            default: begin
                                clr_up   = 1'b1;
                                clr_down = 1'b1;
                            end
                        endcase
                    end
                end
                ST_DOOR_OPEN: begin
                    if (req_here_car || (dir_ind != DIR_DOWN && req_here_up)
                                     || (dir_ind != DIR_UP && req_here_down)) begin
                        clr_car  = 1'b1;
                        clr_up   = (dir_ind != DIR_DOWN);
                        clr_down = (dir_ind != DIR_UP);
                        dwell_d  = '0;
                    end else if (overload) begin
                        dwell_d = '0;
                    end else if (close_btn) begin
                        state_d = ST_DOOR_CLOSING;
                        dwell_d = '0;
                    end else if (sensor_inside) begin
                        dwell_d = '0;
                    end else if (dwell_q == DWELL_LAST) begin
                        state_d = ST_DOOR_CLOSING;
                        dwell_d = '0;
                    end else begin
                        dwell_d = dwell_q + DWELL_W'(1);
                    end
                end
                ST_DOOR_CLOSING: begin
                    if (sensor_inside || open_btn || overload) begin
                        state_d = ST_DOOR_OPENING;
                    end else if (sensor_door == SD_CLOSED) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_FAULT: begin
                    fault_d = 1'b1;
                end
                default: begin
                    state_d = ST_FAULT;
                    fault_d = 1'b1;
                end
            endcase
        end

        case (state_d)
            ST_MOVE_UP:      engine_d = ENG_UP;
            ST_MOVE_DOWN:    engine_d = ENG_DOWN;
            default:         engine_d = ENG_STOP;
        endcase
        case (state_d)
            ST_DOOR_OPENING: door_d = DOOR_OPEN;
            ST_DOOR_CLOSING: door_d = DOOR_CLOSE;
            default:         door_d = DOOR_HOLD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            level_display <= '0;
            dir_ind       <= DIR_NONE;
            dwell_q       <= '0;
            move_q        <= '0;
            engine        <= ENG_STOP;
            door          <= DOOR_HOLD;
            fault         <= 1'b0;
        end else begin
            state_q       <= state_d;
            level_display <= level_d;
            dir_ind       <= dir_d;
            dwell_q       <= dwell_d;
            move_q        <= move_d;
            engine        <= engine_d;
            door          <= door_d;
            fault         <= fault_d;
        end
    end

endmodule

// File: doc/elevator_scan.md
Name: elevator_scan

Overview:
- Parametrised successor to the single-car elevator controller.
- Floor count, door dwell time and motion watchdog are generics.
- Hall and car calls are latched and served in collective-selective (SCAN) order, with per-floor request lamps, a direction indicator and a sticky fault output.
- Sits between the landing/car button panels and the motor/door/position-sensor model, which supplies the arrival and door-status feedback.

Parameters:
- FLOORS, 8, number of floors (2..64); floor 0 is the lowest.
- LEVEL_W, $clog2(FLOORS), width of the floor index.
- DOOR_TIME, 16, clk cycles the door dwells fully open before auto-close.
- MOVE_TIMEOUT, 256, max clk cycles in motion without an arrival pulse before fault.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- open_btn  in  1  car door-open request.
- close_btn  in  1  car door-close request.
- overload  in  1  car overweight; door must not close.
- sensor_inside  in  1  doorway obstruction.
- sensor_up  in  1  one-cycle pulse: car passed/arrived one floor up.
- sensor_down  in  1  one-cycle pulse: car arrived one floor down.
- sensor_door  in  2  01 fully open, 10 fully closed, 00 in transit, 11 invalid.
- btn_in  in  FLOORS  car call buttons.
- btn_up_out  in  FLOORS  hall up buttons (bit FLOORS-1 ignored).
- btn_down_out  in  FLOORS  hall down buttons (bit 0 ignored).
- engine  out  2  00 stop, 01 up, 10 down.
- door  out  2  00 hold, 01 open, 10 close.
- level_display  out  LEVEL_W  current floor.
- req_lamp  out  FLOORS  OR of pending car/up/down calls per floor.
- dir_ind  out  2  00 none, 01 up, 10 down (committed service direction).
- fault  out  1  sticky fault flag.

Behaviour:
- Reset (reset==0 at a clk edge): state IDLE, level 0, all requests cleared, engine=00, door=00, dir_ind=00, fault=0, timers 0.
- Request capture: any asserted button bit sets its request bit at the next edge and stays set until served. req_lamp is registered, so its latency is 1 cycle.
- States: IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPENING, DOOR_OPEN, DOOR_CLOSING, FAULT.
- IDLE (door closed):
  - A request at the current floor, or open_btn, goes to DOOR_OPENING.
  - Otherwise pick a direction: keep dir_ind if requests remain that way, else any request above gives MOVE_UP, else below gives MOVE_DOWN.
  - With no requests, dir_ind becomes 00.
  - engine follows state in the same cycle as the state change (registered).
- MOVE_UP/MOVE_DOWN:
  - On each sensor pulse, level ±1.
  - Stop at the new level if it has a car call or a hall call in the current direction.
  - Also stop if it has the opposite hall call and no requests lie further ahead.
  - Stopping sets engine=00 and goes to DOOR_OPENING in the same edge.
  - open_btn and close_btn are ignored while moving.
- DOOR_OPENING: door=01 until sensor_door==01, then go to DOOR_OPEN. On entry to DOOR_OPEN:
  - clear the car call at the floor;
  - clear the hall call in dir_ind;
  - if nothing remains ahead, flip dir_ind and clear the opposite hall call too.
- DOOR_OPEN: door=00 and the dwell counter counts DOOR_TIME cycles.
  - close_btn expires the dwell immediately, unless overload is set.
  - overload or sensor_inside holds the counter at 0.
  - A new call at the current floor matching dir_ind is cleared and restarts the dwell.
  - On expiry, go to DOOR_CLOSING.
- DOOR_CLOSING: door=10.
  - sensor_inside, open_btn or overload returns to DOOR_OPENING.
  - sensor_door==10 goes to IDLE.
- Simultaneous sensor_up and sensor_down in the same cycle: fault.
- Fault conditions, each entering FAULT:
  - a sensor pulse opposite to engine, or while engine==00;
  - sensor_up at FLOORS-1, or sensor_down at 0 (level never wraps);
  - sensor_door==11;
  - MOVE_TIMEOUT cycles in a MOVE state without an arrival.
- FAULT: engine=00, door=00, fault=1, requests still latched. Exit only by reset.
- Reset mid-motion or mid-door: immediate return to reset values; the car is treated as at floor 0.

Decomposition:
- Shared package elevator_pkg holds:
  - engine codes ENG_STOP/UP/DOWN;
  - door codes DOOR_HOLD/OPEN/CLOSE;
  - sensor_door codes;
  - the state enum;
  - direction codes.
- Sub-module elevator_req_queue (param FLOORS) holds the three request registers, set/clear logic, req_lamp, and the combinational reductions req_above, req_below and req_here_{car,up,down} for a given level.
- The FSM, timers and level counter stay in elevator_scan.

Test Plan (FLOORS=8, DOOR_TIME=4, MOVE_TIMEOUT=32):
- Reset then btn_in[7] pulse → req_lamp[7]=1 next cycle, engine=01. After 7 sensor_up pulses: level_display=7, engine=00, door=01. Feed sensor_door=01 → req_lamp[7]=0; door closes after 4 cycles.
- At level 0 heading up to 6 with btn_down_out[3] and btn_up_out[4] pending → stop at 4 only. Continue to 6, reverse, stop at 3; dir_ind 01→10.
- btn_up_out[2] while at 2, idle, door closed → door=01 with engine staying 00.
- Door at DOOR_OPEN with overload=1 for 20 cycles → door stays 00, no close. Release → close after 4 cycles. sensor_inside during DOOR_CLOSING → door=01.
- Moving up with no sensor pulse for 32 cycles → fault=1, engine=00. Buttons ignored until reset, which clears everything.
- sensor_down pulse while engine=01, or sensor_up at level 7 → fault=1 next cycle.
